memory_arbiter: RTL and testbench

Single-port memory arbiter for the two-stage RV32I pipeline. It shares one memory bus between instruction fetch (iren) and execute-stage data access (dren/dwen). It produces the i_ram_busy and d_ram_busy stall inputs that the hazard unit consumes. Data accesses have priority, and a streak counter bounds instruction starvation. Grants are registered and address/control is latched, so a requester that is flushed mid-transfer cannot corrupt the bus.

---
 rtl/memory_arbiter_if.sv | 44 ++++
 rtl/memory_arbiter.sv | 120 ++++++++++++
 tb/tb_memory_arbiter.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: fetch, data and RAM bus signals of the arbiter.
// master = arbiter side, slave = requesters plus RAM slave.
interface memory_arbiter_if;
  logic        iren;
  logic [31:0] iaddr;
  logic [31:0] irdata;
  logic        i_ram_busy;

  logic        dren;
  logic        dwen;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dbyte_en;
  logic [31:0] drdata;
  logic        d_ram_busy;

  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_byte_en;
  logic [31:0] ram_rdata;
  logic        ram_busy;

  modport master (
    input  iren, iaddr,
    output irdata, i_ram_busy,
    input  dren, dwen, daddr, dwdata, dbyte_en,
    output drdata, d_ram_busy,
    output ram_ren, ram_wen, ram_addr,
    output ram_wdata, ram_byte_en,
    input  ram_rdata, ram_busy
  );

  modport slave (
    output iren, iaddr,
    input  irdata, i_ram_busy,
    output dren, dwen, daddr, dwdata, dbyte_en,
    input  drdata, d_ram_busy,
    input  ram_ren, ram_wen, ram_addr,
    input  ram_wdata, ram_byte_en,
    output ram_rdata, ram_busy
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM bus between fetch and data access.
// Ports: CLK, nRST (async low), bus (memory_arbiter_if.master).
module memory_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic CLK,
  input  logic nRST,
  memory_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    GNT_I,
    GNT_D
  } state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t     state;
  logic [3:0] streak;
  logic       orphan;

  logic d_req;
  logic free;
  logic pick_d;
  logic pick_i;
  logic i_stale;
  logic d_stale;
  logic stale;
  logic orph_now;
  logic i_done;
  logic d_done;

  assign d_req = bus.dren | bus.dwen;

  // Arbitration happens from IDLE or on the completing cycle.
  assign free = (state == IDLE) | ~bus.ram_busy;

  assign pick_d = d_req &
                  ~(bus.iren & (streak == LIM));
  assign pick_i = bus.iren & ~pick_d;

  // Owner no longer asks for what is on the bus.
  assign i_stale = ~bus.iren |
                   (bus.iaddr != bus.ram_addr);
  assign d_stale = ~d_req |
                   (bus.daddr != bus.ram_addr) |
                   (bus.dbyte_en != bus.ram_byte_en) |
                   (bus.dwen != bus.ram_wen);

  always_comb begin
    stale = 1'b0;
    unique case (1'b1)
      state == GNT_I: stale = i_stale;
      state == GNT_D: stale = d_stale;
      default:        stale = 1'b0;
    endcase
  end

  assign orph_now = orphan | stale;

  assign i_done = (state == GNT_I) &
                  ~bus.ram_busy & ~orph_now;
  assign d_done = (state == GNT_D) &
                  ~bus.ram_busy & ~orph_now;

  assign bus.i_ram_busy = bus.iren & ~i_done;
  assign bus.d_ram_busy = d_req & ~d_done;

  assign bus.irdata = bus.ram_rdata;
  assign bus.drdata = bus.ram_rdata;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state           <= IDLE;
      streak          <= 4'd0;
      orphan          <= 1'b0;
      bus.ram_ren     <= 1'b0;
      bus.ram_wen     <= 1'b0;
      bus.ram_addr    <= 32'd0;
      bus.ram_wdata   <= 32'd0;
      bus.ram_byte_en <= 4'd0;
    end else begin
      if (free) begin
        orphan <= 1'b0;
        if (pick_d) begin
          state           <= GNT_D;
          bus.ram_ren     <= ~bus.dwen;
          bus.ram_wen     <= bus.dwen;
          bus.ram_addr    <= bus.daddr;
          bus.ram_wdata   <= bus.dwdata;
          bus.ram_byte_en <= bus.dbyte_en;
        end else if (pick_i) begin
          state           <= GNT_I;
          bus.ram_ren     <= 1'b1;
          bus.ram_wen     <= 1'b0;
          bus.ram_addr    <= bus.iaddr;
          bus.ram_wdata   <= 32'd0;
          bus.ram_byte_en <= 4'hF;
        end else begin
          state       <= IDLE;
          bus.ram_ren <= 1'b0;
          bus.ram_wen <= 1'b0;
        end
      end else if (stale) begin
        orphan <= 1'b1;
      end

      if (!bus.iren) begin
        streak <= 4'd0;
      end else if (free && pick_i) begin
        streak <= 4'd0;
      end else if (free && pick_d &&
                   streak != LIM) begin
        streak <= streak + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_memory_arbiter;

  localparam int LIMIT = 4;

  logic CLK = 1'b0;
  logic nRST = 1'b1;

  memory_arbiter_if bus();

  memory_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the bus and what it asked for.
  // owner 0 = nobody, 1 = fetch, 2 = data.
  int          m_own = 0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_wdata = '0;
  logic [3:0]  m_be = '0;
  logic        m_wr = 1'b0;
  int          m_run = 0;
  bit          m_orph = 1'b0;

  function automatic bit m_free();
    return (m_own == 0) || !bus.ram_busy;
  endfunction

  function automatic bit m_stale();
    if (m_own == 1)
      return !bus.iren || bus.iaddr != m_addr;
    if (m_own == 2)
      return !(bus.dren || bus.dwen) ||
             bus.daddr != m_addr ||
             bus.dbyte_en != m_be ||
             bus.dwen != m_wr;
    return 1'b0;
  endfunction

  function automatic bit m_served(int who);
    return m_own == who && !bus.ram_busy &&
           !m_orph && !m_stale();
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_own  <= 0;
      m_run  <= 0;
      m_orph <= 1'b0;
    end else if (m_free()) begin
      m_orph <= 1'b0;
      if ((bus.dren || bus.dwen) &&
          !(bus.iren && m_run >= LIMIT)) begin
        m_own   <= 2;
        m_addr  <= bus.daddr;
        m_be    <= bus.dbyte_en;
        m_wr    <= bus.dwen;
        m_wdata <= bus.dwdata;
        m_run   <= bus.iren ?
                   ((m_run < LIMIT) ? m_run + 1 : LIMIT) : 0;
      end else if (bus.iren) begin
        m_own  <= 1;
        m_addr <= bus.iaddr;
        m_be   <= 4'hF;
        m_wr   <= 1'b0;
        m_run  <= 0;
      end else begin
        m_own <= 0;
        m_run <= 0;
      end
    end else begin
      if (m_stale()) m_orph <= 1'b1;
      if (!bus.iren) m_run <= 0;
    end
  end

  task automatic clear_reqs();
    bus.iren  = 1'b0;
    bus.dren  = 1'b0;
    bus.dwen  = 1'b0;
  endtask

  task automatic test_reset();
    #1 nRST = 1'b0;
    bus.iren = 1'b1;
    bus.dwen = 1'b1;
    @(negedge CLK);
    checks += 7;
    if (bus.ram_ren !== 1'b0) begin
      errors++;
      $display("FAIL rst_ren: got %b want 0", bus.ram_ren);
    end
    if (bus.ram_wen !== 1'b0) begin
      errors++;
      $display("FAIL rst_wen: got %b want 0", bus.ram_wen);
    end
    if (bus.ram_addr !== 32'd0) begin
      errors++;
      $display("FAIL rst_addr: got %h want 0", bus.ram_addr);
    end
    if (bus.ram_wdata !== 32'd0) begin
      errors++;
      $display("FAIL rst_wdata: got %h want 0", bus.ram_wdata);
    end
    if (bus.ram_byte_en !== 4'd0) begin
      errors++;
      $display("FAIL rst_be: got %h want 0", bus.ram_byte_en);
    end
    if (bus.i_ram_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_ibusy: got %b want 1", bus.i_ram_busy);
    end
    if (bus.d_ram_busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_dbusy: got %b want 1", bus.d_ram_busy);
    end
    clear_reqs();
    #1;
    checks += 2;
    if (bus.i_ram_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_ibusy0: got %b want 0", bus.i_ram_busy);
    end
    if (bus.d_ram_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_dbusy0: got %b want 0", bus.d_ram_busy);
    end
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_idle_fetch();
    bus.iren      = 1'b1;
    bus.iaddr     = 32'h200;
    bus.ram_busy  = 1'b0;
    bus.ram_rdata = 32'h1234_5678;
    #1;
    checks += 2;
    if (bus.i_ram_busy !== 1'b1) begin
      errors++;
      $display("FAIL fetch_wait: got %b want 1", bus.i_ram_busy);
    end
    if (bus.ram_ren !== 1'b0) begin
      errors++;
      $display("FAIL fetch_noren: got %b want 0", bus.ram_ren);
    end
    @(negedge CLK);
    checks += 5;
    if (bus.ram_ren !== 1'b1) begin
      errors++;
      $display("FAIL fetch_ren: got %b want 1", bus.ram_ren);
    end
    if (bus.ram_addr !== 32'h200) begin
      errors++;
      $display("FAIL fetch_addr: got %h want 200", bus.ram_addr);
    end
    if (bus.ram_byte_en !== 4'hF) begin
      errors++;
      $display("FAIL fetch_be: got %h want f", bus.ram_byte_en);
    end
    if (bus.i_ram_busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done: got %b want 0", bus.i_ram_busy);
    end
    if (bus.irdata !== 32'h1234_5678) begin
      errors++;
      $display("FAIL fetch_rdata: got %h want 12345678", bus.irdata);
    end
    bus.iren = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.ram_ren !== 1'b0) begin
      errors++;
      $display("FAIL fetch_release: got %b want 0", bus.ram_ren);
    end
  endtask

  task automatic test_priority();
    string want;
    byte   got;
    want = "DDDDIDDDDI";
    bus.iren     = 1'b1;
    bus.iaddr    = 32'h300;
    bus.dren     = 1'b1;
    bus.daddr    = 32'h2000;
    bus.dbyte_en = 4'hF;
    bus.ram_busy = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      got = "-";
      if (bus.ram_ren && bus.ram_addr == 32'h2000) got = "D";
      if (bus.ram_ren && bus.ram_addr == 32'h300)  got = "I";
      checks++;
      if (got !== want[k]) begin
        errors++;
        $display("FAIL grant_seq[%0d]: got %s want %s",
                 k, got, want[k]);
      end
    end
    clear_reqs();
    @(negedge CLK);
  endtask

  task automatic test_conflict();
    bus.dren     = 1'b1;
    bus.dwen     = 1'b1;
    bus.daddr    = 32'h1000;
    bus.dwdata   = 32'hDEAD_BEEF;
    bus.dbyte_en = 4'h3;
    @(negedge CLK);
    checks += 6;
    if (bus.ram_wen !== 1'b1) begin
      errors++;
      $display("FAIL conf_wen: got %b want 1", bus.ram_wen);
    end
    if (bus.ram_ren !== 1'b0) begin
      errors++;
      $display("FAIL conf_ren: got %b want 0", bus.ram_ren);
    end
    if (bus.ram_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL conf_wdata: got %h want deadbeef", bus.ram_wdata);
    end
    if (bus.ram_byte_en !== 4'h3) begin
      errors++;
      $display("FAIL conf_be: got %h want 3", bus.ram_byte_en);
    end
    if (bus.ram_addr !== 32'h1000) begin
      errors++;
      $display("FAIL conf_addr: got %h want 1000", bus.ram_addr);
    end
    if (bus.d_ram_busy !== 1'b0) begin
      errors++;
      $display("FAIL conf_dbusy: got %b want 0", bus.d_ram_busy);
    end
    clear_reqs();
    @(negedge CLK);
  endtask

  task automatic test_orphan();
    bus.iren     = 1'b1;
    bus.iaddr    = 32'h100;
    bus.ram_busy = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge CLK);
      #1 bus.ram_busy = (c < 4);
      @(negedge CLK);
      checks += 3;
      if (bus.ram_addr !== 32'h100) begin
        errors++;
        $display("FAIL orph_addr[%0d]: got %h want 100", c, bus.ram_addr);
      end
      if (bus.ram_ren !== 1'b1) begin
        errors++;
        $display("FAIL orph_ren[%0d]: got %b want 1", c, bus.ram_ren);
      end
      if (c == 1) bus.iaddr = 32'h400;
      #1;
      if (bus.i_ram_busy !== 1'b1) begin
        errors++;
        $display("FAIL orph_ibusy[%0d]: got %b want 1", c, bus.i_ram_busy);
      end
    end
    @(negedge CLK);
    checks += 3;
    if (bus.ram_addr !== 32'h400) begin
      errors++;
      $display("FAIL orph_next: got %h want 400", bus.ram_addr);
    end
    if (bus.ram_ren !== 1'b1) begin
      errors++;
      $display("FAIL orph_nren: got %b want 1", bus.ram_ren);
    end
    if (bus.i_ram_busy !== 1'b0) begin
      errors++;
      $display("FAIL orph_ndone: got %b want 0", bus.i_ram_busy);
    end
    clear_reqs();
    @(negedge CLK);
  endtask

  task automatic test_async_reset();
    bus.iren     = 1'b1;
    bus.iaddr    = 32'h500;
    bus.dren     = 1'b1;
    bus.daddr    = 32'h3000;
    bus.dbyte_en = 4'hF;
    bus.ram_busy = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(posedge CLK);
      #1 bus.ram_busy = (c == 4);
      @(negedge CLK);
      checks++;
      if (!(bus.ram_ren && bus.ram_addr == 32'h3000)) begin
        errors++;
        $display("FAIL ar_dgrant[%0d]: got ren %b addr %h want 1/3000",
                 c, bus.ram_ren, bus.ram_addr);
      end
    end
    #1 nRST = 1'b0;
    #1;
    checks += 3;
    if (bus.ram_ren !== 1'b0) begin
      errors++;
      $display("FAIL ar_ren: got %b want 0", bus.ram_ren);
    end
    if (bus.ram_wen !== 1'b0) begin
      errors++;
      $display("FAIL ar_wen: got %b want 0", bus.ram_wen);
    end
    if (bus.d_ram_busy !== 1'b1) begin
      errors++;
      $display("FAIL ar_dbusy: got %b want 1", bus.d_ram_busy);
    end
    @(negedge CLK);
    nRST = 1'b1;
    bus.ram_busy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge CLK);
      checks++;
      if (!(bus.ram_ren && bus.ram_addr == 32'h3000)) begin
        errors++;
        $display("FAIL ar_after[%0d]: got ren %b addr %h want 1/3000",
                 c, bus.ram_ren, bus.ram_addr);
      end
    end
    clear_reqs();
    @(negedge CLK);
  endtask

  task automatic test_random();
    logic er;
    logic ew;
    logic eib;
    logic edb;
    for (int n = 0; n < 3000; n++) begin
      @(posedge CLK);
      #1;
      if ($urandom_range(0, 3) == 0) bus.iren = ~bus.iren;
      if ($urandom_range(0, 7) == 0)
        bus.iaddr = $urandom_range(0, 1) ? 32'h100 : 32'h104;
      if ($urandom_range(0, 3) == 0) bus.dren = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) bus.dwen = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        bus.daddr = $urandom_range(0, 1) ? 32'h2000 : 32'h2004;
      if ($urandom_range(0, 7) == 0)
        bus.dbyte_en = $urandom_range(0, 1) ? 4'hF : 4'h3;
      bus.dwdata    = $urandom;
      bus.ram_busy  = ($urandom_range(0, 2) == 0);
      bus.ram_rdata = $urandom;
      @(negedge CLK);
      er  = (m_own == 1) || (m_own == 2 && !m_wr);
      ew  = (m_own == 2) && m_wr;
      eib = bus.iren && !m_served(1);
      edb = (bus.dren || bus.dwen) && !m_served(2);
      checks += 5;
      if (bus.ram_ren !== er || bus.ram_wen !== ew) begin
        errors++;
        $display("FAIL rnd_strobe[%0d]: got %b%b want %b%b",
                 n, bus.ram_ren, bus.ram_wen, er, ew);
      end
      if (bus.i_ram_busy !== eib) begin
        errors++;
        $display("FAIL rnd_ibusy[%0d]: got %b want %b", n, bus.i_ram_busy, eib);
      end
      if (bus.d_ram_busy !== edb) begin
        errors++;
        $display("FAIL rnd_dbusy[%0d]: got %b want %b", n, bus.d_ram_busy, edb);
      end
      if (bus.irdata !== bus.ram_rdata || bus.drdata !== bus.ram_rdata) begin
        errors++;
        $display("FAIL rnd_rdata[%0d]: got %h/%h want %h",
                 n, bus.irdata, bus.drdata, bus.ram_rdata);
      end
      if (m_own != 0 &&
          (bus.ram_addr !== m_addr || bus.ram_byte_en !== m_be ||
           (m_wr && bus.ram_wdata !== m_wdata))) begin
        errors++;
        $display("FAIL rnd_latch[%0d]: got %h/%h/%h want %h/%h/%h",
                 n, bus.ram_addr, bus.ram_byte_en, bus.ram_wdata,
                 m_addr, m_be, m_wdata);
      end
    end
    clear_reqs();
    @(negedge CLK);
  endtask

  initial begin
    bus.iren      = 1'b0;
    bus.iaddr     = '0;
    bus.dren      = 1'b0;
    bus.dwen      = 1'b0;
    bus.daddr     = '0;
    bus.dwdata    = '0;
    bus.dbyte_en  = '0;
    bus.ram_rdata = '0;
    bus.ram_busy  = 1'b0;
    test_reset();
    test_idle_fetch();
    test_priority();
    test_conflict();
    test_orphan();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
